// File: rtl/phys_reg_free_list_if.sv
// phys_reg_free_list_if: rename-side allocation and retire-side free bundle for the physical register free list.
interface phys_reg_free_list_if #(parameter int PREG_W = 6);
  logic              alloc_req;
  logic [PREG_W-1:0] alloc_preg;
  logic              alloc_valid;
  logic              stall;
  logic              free_vld_0;
  logic [PREG_W-1:0] free_preg_0;
  logic              free_vld_1;
  logic [PREG_W-1:0] free_preg_1;
  logic [PREG_W:0]   free_count;
  logic              err_dbl_free;
  logic              err_overflow;
  modport master (
    output alloc_req, free_vld_0, free_preg_0, free_vld_1, free_preg_1,
    input  alloc_preg, alloc_valid, stall, free_count, err_dbl_free, err_overflow
  );
  modport slave (
    input  alloc_req, free_vld_0, free_preg_0, free_vld_1, free_preg_1,
    output alloc_preg, alloc_valid, stall, free_count, err_dbl_free, err_overflow
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: circular FIFO of free physical register tags with per-tag membership to block double frees.
module phys_reg_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int PREG_W    = 6,
  parameter int NUM_AREGS = 32
) (
  input logic                clk,
  input logic                rst,
  phys_reg_free_list_if.slave bus
);
  logic [PREG_W-1:0]    fifo_q [NUM_PREGS];
  logic [PREG_W-1:0]    fifo_d [NUM_PREGS];
  logic [NUM_PREGS-1:0] in_list_q, in_list_d;
  logic [PREG_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PREG_W:0]      count_q, count_d;
  logic                 err_dbl_q, err_ovf_q;
  logic                 pop, dup, nz0, nz1, cand0, cand1, dbl0, dbl1, push0, push1, ovf;
  logic [PREG_W+1:0]    cap, cnt_x;
  always_comb begin
    pop   = bus.alloc_req && count_q != '0;
    cap   = (PREG_W+2)'(NUM_PREGS) + (PREG_W+2)'(pop);
    cnt_x = {1'b0, count_q};
    nz0   = bus.free_vld_0 && bus.free_preg_0 != '0;
    nz1   = bus.free_vld_1 && bus.free_preg_1 != '0;
    dup   = bus.free_vld_0 && bus.free_preg_0 == bus.free_preg_1;
    cand0 = nz0 && !in_list_q[bus.free_preg_0];
    dbl0  = nz0 && in_list_q[bus.free_preg_0];
    cand1 = nz1 && !in_list_q[bus.free_preg_1] && !dup;
    dbl1  = nz1 && (in_list_q[bus.free_preg_1] || dup);
    // Slot 1's room check accounts for slot 0's push landing first.
    push0 = cand0 && cnt_x < cap;
    push1 = cand1 && cnt_x + (PREG_W+2)'(push0) < cap;
    ovf   = (cand0 && !push0) || (cand1 && !push1);
    head_d  = head_q + PREG_W'(pop);
    tail_d  = tail_q + PREG_W'(push0) + PREG_W'(push1);
    count_d = count_q + (PREG_W+1)'(push0) + (PREG_W+1)'(push1) - (PREG_W+1)'(pop);
    fifo_d    = fifo_q;
    in_list_d = in_list_q;
    if (pop) in_list_d[fifo_q[head_q]] = 1'b0;
    if (push0) begin
      fifo_d[tail_q] = bus.free_preg_0;
      in_list_d[bus.free_preg_0] = 1'b1;
    end
    if (push1) begin
      fifo_d[tail_q + PREG_W'(push0)] = bus.free_preg_1;
      in_list_d[bus.free_preg_1] = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        fifo_q[i]    <= (i < NUM_PREGS - NUM_AREGS) ? PREG_W'(i + NUM_AREGS) : '0;
        in_list_q[i] <= i >= NUM_AREGS;
      end
      head_q    <= '0;
      tail_q    <= PREG_W'(NUM_PREGS - NUM_AREGS);
      count_q   <= (PREG_W+1)'(NUM_PREGS - NUM_AREGS);
      err_dbl_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      fifo_q    <= fifo_d;
      in_list_q <= in_list_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      err_dbl_q <= err_dbl_q | dbl0 | dbl1;
      err_ovf_q <= err_ovf_q | ovf;
    end
  end
  assign bus.alloc_preg   = fifo_q[head_q];
  assign bus.alloc_valid  = count_q != '0;
  assign bus.stall        = bus.alloc_req && count_q == '0;
  assign bus.free_count   = count_q;
  assign bus.err_dbl_free = err_dbl_q;
  assign bus.err_overflow = err_ovf_q;
endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb_phys_reg_free_list: directed checks of allocation, two-wide free, double-free rejection, wrap and reset.
module tb_phys_reg_free_list;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;
  int   q[$];
  int   popped[$];
  phys_reg_free_list_if #(.PREG_W(6)) bus ();
  phys_reg_free_list dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.alloc_req   = 1'b0;
    bus.free_vld_0  = 1'b0;
    bus.free_preg_0 = '0;
    bus.free_vld_1  = 1'b0;
    bus.free_preg_1 = '0;
  endtask
  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic free1(input int t);
    idle();
    bus.free_vld_0  = 1'b1;
    bus.free_preg_0 = 6'(t);
    tick();
    idle();
  endtask
  initial begin
    idle();
    do_reset();
    chk("rst_count", int'(bus.free_count), 32);
    chk("rst_preg", int'(bus.alloc_preg), 32);
    chk("rst_valid", int'(bus.alloc_valid), 1);
    chk("rst_stall", int'(bus.stall), 0);
    chk("rst_dbl", int'(bus.err_dbl_free), 0);
    chk("rst_ovf", int'(bus.err_overflow), 0);
    for (int i = 0; i < 32; i++) begin
      bus.alloc_req = 1'b1;
      #1;
      chk("drain_preg", int'(bus.alloc_preg), 32 + i);
      tick();
    end
    chk("empty_valid", int'(bus.alloc_valid), 0);
    chk("empty_stall", int'(bus.stall), 1);
    chk("empty_count", int'(bus.free_count), 0);
    bus.free_vld_0  = 1'b1;
    bus.free_preg_0 = 6'd40;
    #1;
    chk("nobypass_stall", int'(bus.stall), 1);
    tick();
    idle();
    #1;
    chk("nobypass_preg", int'(bus.alloc_preg), 40);
    chk("nobypass_count", int'(bus.free_count), 1);
    bus.alloc_req = 1'b1;
    tick();
    idle();
    chk("reempty_count", int'(bus.free_count), 0);
    bus.free_vld_0  = 1'b1;
    bus.free_preg_0 = 6'd45;
    bus.free_vld_1  = 1'b1;
    bus.free_preg_1 = 6'd50;
    tick();
    idle();
    chk("two_count", int'(bus.free_count), 2);
    chk("two_first", int'(bus.alloc_preg), 45);
    bus.alloc_req = 1'b1;
    tick();
    chk("two_second", int'(bus.alloc_preg), 50);
    tick();
    idle();
    chk("two_drained", int'(bus.free_count), 0);
    chk("two_no_err", int'(bus.err_dbl_free), 0);
    do_reset();
    free1(0);
    chk("tag0_count", int'(bus.free_count), 32);
    chk("tag0_no_err", int'(bus.err_dbl_free), 0);
    free1(33);
    chk("dbl_count", int'(bus.free_count), 32);
    chk("dbl_err", int'(bus.err_dbl_free), 1);
    do_reset();
    bus.free_vld_0  = 1'b1;
    bus.free_preg_0 = 6'd12;
    bus.free_vld_1  = 1'b1;
    bus.free_preg_1 = 6'd12;
    tick();
    idle();
    chk("dup_count", int'(bus.free_count), 33);
    chk("dup_err", int'(bus.err_dbl_free), 1);
    do_reset();
    bus.alloc_req   = 1'b1;
    bus.free_vld_0  = 1'b1;
    bus.free_preg_0 = 6'd32;
    tick();
    idle();
    chk("headfree_count", int'(bus.free_count), 31);
    chk("headfree_err", int'(bus.err_dbl_free), 1);
    chk("headfree_preg", int'(bus.alloc_preg), 33);
    do_reset();
    q = {};
    popped = {};
    for (int t = 32; t < 64; t++) q.push_back(t);
    for (int i = 0; i < 80; i++) begin
      int ft;
      ft = (i < 31) ? i + 1 : popped[i - 31];
      bus.alloc_req   = 1'b1;
      bus.free_vld_0  = 1'b1;
      bus.free_preg_0 = 6'(ft);
      #1;
      chk("wrap_preg", int'(bus.alloc_preg), q[0]);
      chk("wrap_count", int'(bus.free_count), q.size());
      popped.push_back(q.pop_front());
      q.push_back(ft);
      tick();
    end
    idle();
    chk("wrap_end_count", int'(bus.free_count), q.size());
    chk("wrap_end_preg", int'(bus.alloc_preg), q[0]);
    chk("wrap_no_err", int'(bus.err_dbl_free), 0);
    chk("wrap_no_ovf", int'(bus.err_overflow), 0);
    do_reset();
    bus.alloc_req = 1'b1;
    repeat (10) tick();
    idle();
    free1(1);
    free1(2);
    free1(3);
    free1(50);
    chk("mid_count", int'(bus.free_count), 25);
    chk("mid_err", int'(bus.err_dbl_free), 1);
    rst = 1'b1;
    bus.alloc_req   = 1'b1;
    bus.free_vld_0  = 1'b1;
    bus.free_preg_0 = 6'd5;
    tick();
    rst = 1'b0;
    idle();
    chk("mrst_count", int'(bus.free_count), 32);
    chk("mrst_preg", int'(bus.alloc_preg), 32);
    chk("mrst_dbl", int'(bus.err_dbl_free), 0);
    chk("mrst_ovf", int'(bus.err_overflow), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
